// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache. Data wins a simultaneous arrival,
// requesters alternate under load, and a RAM ERROR or a service timeout forces a release.
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CW          = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          iwait,
    output logic [DW-1:0] iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic          dwait,
    output logic [DW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic [1:0]    ramstate,
    output logic          mem_err,
    output logic [CW-1:0] icnt,
    output logic [CW-1:0] dcnt
);
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] TO_CNT    = SW'(TIMEOUT_CYC);
    localparam logic [1:0]    RS_ACCESS = 2'd2;
    localparam logic [1:0]    RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, DSERV = 2'd1, ISERV = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;
    logic [CW-1:0] icnt_q, icnt_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          d_req_s, serv_req_s, other_req_s, done_s, ok_s, abort_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            return v;
        end else begin
            return v + CW'(1);
        end
    endfunction

    // Decode the served/other request and the completion or abort of the current service
    always_comb begin
        d_req_s     = dREN | dWEN;
        serv_req_s  = 1'b0;
        other_req_s = 1'b0;
        case (state_q)
            DSERV: begin
                serv_req_s  = d_req_s;
                other_req_s = iREN;
            end
            ISERV: begin
                serv_req_s  = iREN;
                other_req_s = d_req_s;
            end
            default: begin
                serv_req_s  = 1'b0;
                other_req_s = 1'b0;
            end
        endcase
        // ACCESS takes precedence over a coincident timeout, so ok_s decides the count
        done_s  = serv_req_s & ((ramstate == RS_ACCESS) | (ramstate == RS_ERROR) | (cnt_q == TO_CNT));
        ok_s    = serv_req_s & (ramstate == RS_ACCESS);
        abort_s = (state_q != IDLE) & ~serv_req_s;
    end

    // Next-state, service counter, sticky error and access counters
    always_comb begin
        state_d   = state_q;
        cnt_d     = {SW{1'b0}};
        mem_err_d = mem_err_q | (done_s & ~ok_s);
        icnt_d    = (ok_s && (state_q == ISERV)) ? sat_inc(icnt_q) : icnt_q;
        dcnt_d    = (ok_s && (state_q == DSERV)) ? sat_inc(dcnt_q) : dcnt_q;
        case (state_q)
            IDLE: begin
                if (d_req_s) begin
                    state_d = DSERV;
                end else if (iREN) begin
                    state_d = ISERV;
                end else begin
                    state_d = IDLE;
                end
            end
            DSERV, ISERV: begin
                if (done_s || abort_s) begin
                    if (other_req_s) begin
                        state_d = (state_q == DSERV) ? ISERV : DSERV;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM strobes and per-requester handshake, combinational from state and live requests
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = {AW{1'b0}};
        ramstore = {DW{1'b0}};
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = {DW{1'b0}};
        dload    = {DW{1'b0}};
        case (state_q)
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (done_s) begin
                    dwait = 1'b0;
                    dload = ok_s ? ramload : {DW{1'b0}};
                end else begin
                    dwait = 1'b1;
                    dload = {DW{1'b0}};
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (done_s) begin
                    iwait = 1'b0;
                    iload = ok_s ? ramload : {DW{1'b0}};
                end else begin
                    iwait = 1'b1;
                    iload = {DW{1'b0}};
                end
            end
            default: begin
                ramREN = 1'b0;
                ramWEN = 1'b0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= {SW{1'b0}};
            mem_err_q <= 1'b0;
            icnt_q    <= {CW{1'b0}};
            dcnt_q    <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            icnt_q    <= icnt_d;
            dcnt_q    <= dcnt_d;
        end
    end

    assign mem_err = mem_err_q;
    assign icnt    = icnt_q;
    assign dcnt    = dcnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic,
// checked against an ownership-level reference model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int CW = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [AW-1:0] iaddr = '0, daddr = '0;
    logic [DW-1:0] dstore = '0, ramload = '0;
    logic [1:0]    ramstate = 2'd0;
    logic          iwait, dwait, ramREN, ramWEN, mem_err;
    logic [DW-1:0] iload, dload, ramstore;
    logic [AW-1:0] ramaddr;
    logic [CW-1:0] icnt, dcnt;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO), .CW(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .mem_err(mem_err), .icnt(icnt), .dcnt(dcnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          ren, wen, err;
        logic [AW-1:0] addr;
        logic [DW-1:0] store;
        logic [CW-1:0] ic, dc;
    } cyc_t;
    typedef struct {
        int            who;   // 1 = data, 2 = instruction
        logic [DW-1:0] load;
    } cmp_t;

    cyc_t  cyc_q[$];
    cmp_t  cmp_q[$];
    int    nvec = 0, nerr = 0;
    // reference model: who owns the port, how long it has held it, and the counters
    int    own = 0, age = 0, ic_m = 0, dc_m = 0;
    bit    err_m = 1'b0;
    string glog = "";
    cyc_t  mc;
    cmp_t  mm;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk_str(input string name, input string act, input string exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endfunction

    // One clock of stimulus; the model predicts this cycle's outputs and the owner for the next
    task automatic cycle(input bit ir, input bit dr, input bit dw, input logic [AW-1:0] ia,
                         input logic [AW-1:0] da, input logic [DW-1:0] ds,
                         input logic [1:0] rs, input logic [DW-1:0] rl);
        cyc_t c;
        cmp_t m;
        bit   dq, req, oth, fin;
        @(posedge CLK);
        #1;
        iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
        dq = dr | dw;
        c.ren = 1'b0; c.wen = 1'b0; c.addr = '0; c.store = '0;
        if (own == 1) begin
            c.addr = da; c.store = ds; c.wen = dw; c.ren = dr & ~dw;
        end else if (own == 2) begin
            c.addr = ia; c.ren = ir;
        end
        c.err = err_m; c.ic = CW'(ic_m); c.dc = CW'(dc_m);
        cyc_q.push_back(c);
        if (own == 0) begin
            own = dq ? 1 : (ir ? 2 : 0);
            age = 0;
        end else begin
            req = (own == 1) ? dq : ir;
            oth = (own == 1) ? ir : dq;
            fin = req && (rs == ACC || rs == ERR || age == TO);
            if (fin) begin
                m.who  = own;
                m.load = (rs == ACC) ? rl : '0;
                cmp_q.push_back(m);
                if (rs != ACC) err_m = 1'b1;
                else if (own == 1 && dc_m < (1 << CW) - 1) dc_m++;
                else if (own == 2 && ic_m < (1 << CW) - 1) ic_m++;
            end
            if (!req || fin) begin
                own = oth ? 3 - own : 0;
                age = 0;
            end else begin
                age++;
            end
        end
    endtask

    // Assert reset immediately, check the reset outputs, release it mid-cycle two edges later
    task automatic rst_now();
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        cyc_q.delete(); cmp_q.delete();
        own = 0; age = 0; ic_m = 0; dc_m = 0; err_m = 1'b0; glog = "";
        #1;
        chk("rst_waits", {iwait, dwait}, 2'b11);
        chk("rst_strobes", {ramREN, ramWEN}, 2'b00);
        chk("rst_addr_store", {ramaddr, ramstore}, 64'd0);
        chk("rst_loads", {iload, dload}, 64'd0);
        chk("rst_regs", {mem_err, icnt, dcnt}, '0);
        repeat (2) @(posedge CLK);
        #3;
        nRST = 1'b1;
    endtask

    // Monitor: per-cycle strobes/registers, and a completion pop whenever a wait drops
    always @(negedge CLK) begin
        if (nRST) begin
            if (cyc_q.size() > 0) begin
                mc = cyc_q.pop_front();
                chk("ram_strobes", {ramREN, ramWEN}, {mc.ren, mc.wen});
                chk("ramaddr", ramaddr, mc.addr);
                chk("ramstore", ramstore, mc.store);
                chk("mem_err", mem_err, mc.err);
                chk("counters", {icnt, dcnt}, {mc.ic, mc.dc});
            end
            if (!iwait || !dwait) begin
                if (cmp_q.size() == 0) begin
                    chk("spurious_done", {!dwait, !iwait}, 2'b00);
                end else begin
                    mm = cmp_q.pop_front();
                    chk("done_who", {!dwait, !iwait}, (mm.who == 1) ? 2'b10 : 2'b01);
                    chk("done_load", (mm.who == 1) ? dload : iload, mm.load);
                    chk("unserved_load", (mm.who == 1) ? iload : dload, 32'd0);
                    glog = {glog, (mm.who == 1) ? "D" : "I"};
                end
            end else if (cmp_q.size() > 0) begin
                mm = cmp_q.pop_front();
                chk("missing_done", {!dwait, !iwait}, (mm.who == 1) ? 2'b10 : 2'b01);
            end
        end
    end

    initial begin
        @(posedge CLK); #2; rst_now();

        // single data read, ACCESS two cycles after the strobe
        cycle(0, 1, 0, '0, 32'h40, '0, FREE, '0);
        cycle(0, 1, 0, '0, 32'h40, '0, BUSY, '0);
        #1 chk("t1_strobe", {ramREN, ramaddr}, {1'b1, 32'h40});
        cycle(0, 1, 0, '0, 32'h40, '0, BUSY, '0);
        cycle(0, 1, 0, '0, 32'h40, '0, ACC, 32'hDEADBEEF);
        #1 chk("t1_done", {dwait, dload}, {1'b0, 32'hDEADBEEF});
        cycle(0, 0, 0, '0, '0, '0, FREE, '0);
        #1 chk("t1_dcnt_idle", {dcnt, ramREN, dwait}, {4'd1, 1'b0, 1'b1});

        // reset during a data service
        cycle(0, 1, 0, '0, 32'h44, '0, FREE, '0);
        cycle(0, 1, 0, '0, 32'h44, '0, BUSY, '0);
        #1 chk("t6_pre", {ramREN, dcnt}, {1'b1, 4'd1});
        #1 rst_now();
        cycle(0, 1, 0, '0, 32'h48, '0, FREE, '0);
        cycle(0, 1, 0, '0, 32'h48, '0, ACC, 32'h0BADF00D);
        cycle(0, 0, 0, '0, '0, '0, FREE, '0);
        #1 chk("t6_after", dcnt, 4'd1);

        // simultaneous arrival
        @(posedge CLK); #2; rst_now();
        cycle(1, 1, 0, 32'h100, 32'h200, '0, ACC, 32'h1);
        cycle(1, 1, 0, 32'h100, 32'h200, '0, ACC, 32'h2);
        cycle(1, 0, 0, 32'h100, 32'h200, '0, ACC, 32'h3);
        cycle(0, 0, 0, '0, '0, '0, FREE, '0);
        #1 chk("t2_cnt", {icnt, dcnt}, {4'd1, 4'd1});
        chk_str("t2_order", glog, "DI");

        // both held for eight completions
        @(posedge CLK); #2; rst_now();
        cycle(1, 1, 0, 32'h10, 32'h20, '0, FREE, '0);
        for (int k = 0; k < 8; k++) cycle(1, 1, 0, 32'h10, 32'h20, '0, ACC, $urandom);
        cycle(0, 0, 0, '0, '0, '0, FREE, '0);
        #1 chk("t3_cnt", {icnt, dcnt}, {4'd4, 4'd4});
        chk_str("t3_order", glog, "DIDIDIDI");

        // write wins over read
        @(posedge CLK); #2; rst_now();
        cycle(0, 1, 1, '0, 32'h80, 32'h12345678, FREE, '0);
        cycle(0, 1, 1, '0, 32'h80, 32'h12345678, BUSY, '0);
        #1 chk("t4_write", {ramWEN, ramREN, ramstore, ramaddr}, {1'b1, 1'b0, 32'h12345678, 32'h80});
        cycle(0, 1, 1, '0, 32'h80, 32'h12345678, ACC, 32'h5555AAAA);
        cycle(0, 0, 0, '0, '0, '0, FREE, '0);

        // timeout with RAM held BUSY
        @(posedge CLK); #2; rst_now();
        cycle(1, 0, 0, 32'h300, '0, '0, FREE, '0);
        for (int k = 1; k <= 8; k++) cycle(1, 0, 0, 32'h300, '0, '0, BUSY, 32'hFFFFFFFF);
        #1 chk("t5_wait8", iwait, 1'b1);
        cycle(1, 0, 0, 32'h300, '0, '0, BUSY, 32'hFFFFFFFF);
        #1 chk("t5_release", {iwait, iload}, {1'b0, 32'd0});
        cycle(0, 0, 0, '0, '0, '0, FREE, '0);
        #1 chk("t5_err", {mem_err, icnt}, {1'b1, 4'd0});
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, '0, 32'h4, '0, ACC, $urandom);
        #1 chk("t5_sticky", mem_err, 1'b1);

        // randomized traffic; odd phases make ACCESS rare so timeouts happen
        for (int ph = 0; ph < 4; ph++) begin
            @(posedge CLK); #2; rst_now();
            for (int k = 0; k < 600; k++) begin
                int r;
                logic [1:0] rs;
                r = $urandom_range(0, 99);
                if (ph % 2 == 1) rs = (r < 3) ? ACC : (r < 5) ? ERR : (r < 60) ? BUSY : FREE;
                else             rs = (r < 40) ? ACC : (r < 44) ? ERR : (r < 85) ? BUSY : FREE;
                cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                      $urandom, $urandom, $urandom, rs, $urandom);
            end
        end
        cycle(0, 0, 0, '0, '0, '0, FREE, '0);
        cycle(0, 0, 0, '0, '0, '0, FREE, '0);
        @(negedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
